uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial transmitter producing asynchronous framed serial data: start bit, LSB-first data, optional parity, stop bit(s).
- Sits on the output side of a serial link and drives the line that the receiver's synchronizer/edge-detector front end samples; the receiver detects the start bit as a falling edge of the idle-high line.
- Parallel side uses a valid/ready handshake.
- The bit timebase is an internal per-bit clock counter; no external baud strobe.

Parameters:
- BIT_PERIOD, default 10: clock cycles per serial bit; legal range is 2 or more.
- DATA_BITS, default 8: data bits per frame; legal range 5 to 9.
- PARITY_EN, default 1'b0: when 1, a parity bit is inserted after the data bits.
- PARITY_ODD, default 1'b0: when 1, odd parity; when 0, even parity. Ignored if PARITY_EN=0.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- tx_data  input  DATA_BITS  word to transmit; sampled only on an accept.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word. High only in IDLE.
- serial_out  output  1  serial line, registered; idles at 1.
- tx_busy  output  1  high while a frame is in progress (any state except IDLE).
- tx_done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state=IDLE, serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Bit counter and shift register clear to 0.
  - A reset mid-frame aborts the frame: the line returns to 1 on the next cycle and the partial frame is dropped.
- Accept:
  - An accept occurs on a cycle where state=IDLE and tx_valid=1 (tx_ready=1).
  - On accept, tx_data is latched into the shift register; parity is computed from the latched word.
  - tx_data and tx_valid are don't-care outside IDLE.
- States: IDLE -> START -> DATA -> [PARITY if PARITY_EN] -> STOP -> IDLE.
  - IDLE: serial_out=1. On accept, go to START.
  - START: serial_out=0 for BIT_PERIOD cycles. The first 0 appears in the cycle after the accept edge (1-cycle latency).
  - DATA: DATA_BITS bits, LSB first, each held BIT_PERIOD cycles.
  - PARITY: one bit period.
    - Even parity: bit = XOR of the data bits.
    - Odd parity: bit = inverted XOR of the data bits.
  - STOP: serial_out=1 for STOP_BITS*BIT_PERIOD cycles.
- Bit timing:
  - The cycle counter runs 0..BIT_PERIOD-1 and wraps.
  - A bit advances when the counter reaches BIT_PERIOD-1.
  - A separate bit index counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
  - Frame length on the line is (1+DATA_BITS+PARITY_EN+STOP_BITS)*BIT_PERIOD cycles, measured from the first start-bit cycle.
- Completion:
  - On the last cycle of the final stop bit, the FSM returns to IDLE.
  - tx_done=1 and tx_ready=1 in the first IDLE cycle.
  - tx_busy=0 in that same cycle.
- Back-to-back:
  - If tx_valid is held high, the next accept happens in that first IDLE cycle.
  - The line stays 1 for exactly that one extra cycle before the next start bit, so the minimum inter-frame gap is 1 clock.
- Glitch-free output: serial_out comes directly from a flop, with no combinational path from inputs.

Test Plan:
- Reset values: assert rst for 3 cycles with tx_valid=1 -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0; no frame starts while rst=1.
- Basic frame (BIT_PERIOD=4, 8N1): accept tx_data=8'hA5 -> serial_out is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
  - tx_done pulses 40 cycles after the first start cycle.
  - tx_busy is high for exactly 40 cycles.
- Parity (PARITY_EN=1, BIT_PERIOD=4): tx_data=8'h07 -> parity bit=1 when PARITY_ODD=0 and 0 when PARITY_ODD=1; frame length is 44 cycles.
- Back-to-back: hold tx_valid=1 with 8'h00, then 8'hFF -> exactly one idle cycle at 1 between the two frames; the second frame's bits are all 1 after its start bit.
- Handshake hold-off: toggle tx_data and tx_valid during a frame -> transmitted bits are unaffected; tx_ready stays 0 until tx_done.
- Mid-frame reset: assert rst in the 3rd data bit -> serial_out=1 the next cycle, state IDLE; a subsequent accept of 8'h3C transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// Asynchronous serial transmitter. A word accepted on the valid/ready handshake
// is sent as one frame on an idle-high line:
//   start bit (0), DATA_BITS data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1).
// Each bit is held for BIT_PERIOD clock cycles. An internal cycle counter sets
// the bit timing, so no external baud strobe is needed.
//
// Parameters:
//   BIT_PERIOD  clock cycles per serial bit (2 or more)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY_EN   1 inserts a parity bit after the data bits
//   PARITY_ODD  1 selects odd parity, 0 selects even (used only when PARITY_EN=1)
//   STOP_BITS   number of stop bits (1 or 2)
//
// Ports:
//   clk         system clock; all logic uses the rising edge
//   rst         synchronous active-high reset; aborts any frame in progress
//   tx_data     word to send; sampled only on an accept
//   tx_valid    tx_data is valid
//   tx_ready    block can accept a word (high only in IDLE)
//   serial_out  serial line driven straight from a flop; idles at 1
//   tx_busy     high while a frame is in progress
//   tx_done     one-cycle pulse in the first IDLE cycle after the final stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int   BIT_PERIOD = 10,
    parameter int   DATA_BITS  = 8,
    parameter logic PARITY_EN  = 1'b0,
    parameter logic PARITY_ODD = 1'b0,
    parameter int   STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Counter widths. The bit index must hold DATA_BITS-1 (at most 8) and
    // STOP_BITS-1, so 4 bits are enough for every legal setting.
    localparam int CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity of a data word. The XOR of the bits gives even parity, and
    // inverting it gives odd parity.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] word,
                                         input logic                 odd);
        return (^word) ^ odd;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_s;
    logic                 par_r;
    logic                 par_s;
    logic                 done_s;
    logic                 line_s;
    logic                 bit_end_s;

    // Next-state, counter, shift and line-value logic for the frame sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        par_s     = par_r;
        done_s    = 1'b0;
        line_s    = 1'b1;
        bit_end_s = (cnt_r == CNT_W'(BIT_PERIOD - 1));

        case (state_r)
            S_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                idx_s = {IDX_W{1'b0}};
                if (tx_valid) begin
                    state_s = S_START;
                    shift_s = tx_data;
                    par_s   = calc_parity(tx_data, PARITY_ODD);
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_START: begin
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    state_s = S_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    // Drop the bit just sent so bit 0 always holds the
                    // current data bit.
                    shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                    if (idx_r == IDX_W'(DATA_BITS - 1)) begin
                        idx_s   = {IDX_W{1'b0}};
                        state_s = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            S_PARITY: begin
                if (bit_end_s) begin
                    cnt_s   = {CNT_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                    state_s = S_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end_s) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (idx_r == IDX_W'(STOP_BITS - 1)) begin
                        idx_s   = {IDX_W{1'b0}};
                        state_s = S_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_s = S_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = {IDX_W{1'b0}};
            end
        endcase

        // The line level is derived from the next state, so the serial_out
        // flop shows each new bit in the same cycle that its state begins.
        // This gives the first start-bit cycle right after the accept edge.
        case (state_s)
            S_IDLE:   line_s = 1'b1;
            S_START:  line_s = 1'b0;
            S_DATA:   line_s = shift_s[0];
            S_PARITY: line_s = par_s;
            S_STOP:   line_s = 1'b1;
            default:  line_s = 1'b1;
        endcase
    end

    // Sequencer state, counters, and shift register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            shift_r <= {DATA_BITS{1'b0}};
            par_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            par_r   <= par_s;
        end
    end

    // Registered outputs. Each one follows the state that is being entered,
    // so it always matches state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            serial_out <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            serial_out <= line_s;
            tx_ready   <= (state_s == S_IDLE);
            tx_busy    <= (state_s != S_IDLE);
            tx_done    <= done_s;
        end
    end

endmodule
